clm_decoder: RTL and testbench

Bit-serial decoder that maps a redundant CLM field element (degree < 8+D polynomial over GF(2)) back to its canonical 8-bit GF(2^8) value by reducing it modulo the AES polynomial m(x) = x^8+x^4+x^3+x+1 (9'h11B). It is the inverse of the CLM encoder and sits at the output of the masked datapath, after the multiplier. It uses the same drdy_i/drdy_o single-cycle-strobe handshake as the multiplier, so multiplier results feed it directly. One reduction step runs per clock, so latency is fixed and data-independent.

---
 rtl/clm_decoder.sv | 86 ++++++++
 tb/tb_clm_decoder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clm_decoder.sv
// Bit-serial reduction of a redundant CLM element (degree < 8+D) modulo M,
// one MSB-first step per clock, giving a fixed D-cycle latency.
`timescale 1ns/1ps
module clm_decoder #(
  parameter int         D = 8,
  parameter logic [8:0] M = 9'h11B,
  localparam int        W = 8 + D
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         drdy_i,
  input  logic [W-1:0] din,
  output logic         drdy_o,
  output logic [7:0]   dout,
  output logic         busy
);

  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam int KW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    DONE
  } state_t;

  state_t         state;
  logic [W-1:0]   r;
  logic [CW-1:0]  cnt;
  logic [7:0]     dout_q;

  logic [KW-1:0]  k;
  logic [W-1:0]   m_shift;
  logic [W-1:0]   r_step;

  // Step cnt clears bit 8+cnt using M aligned under it; bits above k are never touched.
  always_comb begin
    k       = KW'(cnt) + KW'(8);
    m_shift = W'(M) << cnt;
    r_step  = r[k] ? (r ^ m_shift) : r;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      r      <= '0;
      cnt    <= '0;
      dout_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (drdy_i) begin
            r     <= din;
            cnt   <= CW'(D - 1);
            state <= REDUCE;
          end
        end
        REDUCE: begin
          r <= r_step;
          if (cnt == '0) begin
            dout_q <= r_step[7:0];
            state  <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        // A strobe in the result cycle is accepted directly for full throughput.
        DONE: begin
          if (drdy_i) begin
            r     <= din;
            cnt   <= CW'(D - 1);
            state <= REDUCE;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy   = (state == REDUCE);
  assign drdy_o = (state == DONE);
  assign dout   = dout_q;

endmodule

// File: tb/tb_clm_decoder.sv
// Self-checking bench for clm_decoder: directed steps for D=8 plus random
// comparison against a power-of-x reference for D=8 and D=4.
`timescale 1ns/1ps
module tb_clm_decoder;

  typedef struct {
    logic [7:0] val;
    int         acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        drdy_i8 = 1'b0;
  logic [15:0] din8 = '0;
  logic        drdy_o8, busy8;
  logic [7:0]  dout8;

  logic        drdy_i4 = 1'b0;
  logic [11:0] din4 = '0;
  logic        drdy_o4, busy4;
  logic [7:0]  dout4;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int pulses8 = 0;
  int pulses4 = 0;
  int last_pulse8 = 0;
  int prev_pulse8 = 0;

  exp_t q8[$];
  exp_t q4[$];

  logic [15:0] vec_in [6] = '{16'h0000, 16'h011B, 16'h0100, 16'h8000, 16'hB2F4, 16'hFFFF};
  logic [7:0]  vec_exp[5] = '{8'h00, 8'h00, 8'h1B, 8'h2F, 8'h0B};

  clm_decoder #(.D(8)) dut8 (
    .clk    (clk),
    .rst    (rst),
    .drdy_i (drdy_i8),
    .din    (din8),
    .drdy_o (drdy_o8),
    .dout   (dout8),
    .busy   (busy8)
  );

  clm_decoder #(.D(4)) dut4 (
    .clk    (clk),
    .rst    (rst),
    .drdy_i (drdy_i4),
    .din    (din4),
    .drdy_o (drdy_o4),
    .dout   (dout4),
    .busy   (busy4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Reference: sum of x^i mod M for each set bit, with x^i built by repeated xtime.
  function automatic logic [7:0] ref_mod(input logic [31:0] v, input int w);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = 8'h01;
    for (int i = 0; i < w; i++) begin
      if (v[i]) acc = acc ^ p;
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
    end
    return acc;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (drdy_o8) begin
      exp_t e;
      pulses8++;
      prev_pulse8 = last_pulse8;
      last_pulse8 = cycle;
      check_output("expected_pulse8", 32'(q8.size() != 0), 32'd1);
      if (q8.size() != 0) begin
        e = q8.pop_front();
        check_output("dout8", 32'(dout8), 32'(e.val));
        check_output("latency8", 32'(cycle - e.acc), 32'd8);
      end
    end
  end

  always @(negedge clk) begin
    if (drdy_o4) begin
      exp_t e;
      pulses4++;
      check_output("expected_pulse4", 32'(q4.size() != 0), 32'd1);
      if (q4.size() != 0) begin
        e = q4.pop_front();
        check_output("dout4", 32'(dout4), 32'(e.val));
        check_output("latency4", 32'(cycle - e.acc), 32'd4);
      end
    end
  end

  task automatic apply_stimulus8(input logic [15:0] v, input bit accept);
    exp_t e;
    drdy_i8 = 1'b1;
    din8    = v;
    @(posedge clk);
    #1;
    if (accept) begin
      e.val = ref_mod(32'(v), 16);
      e.acc = cycle;
      q8.push_back(e);
    end
    drdy_i8 = 1'b0;
  endtask

  task automatic apply_stimulus4(input logic [11:0] v);
    exp_t e;
    drdy_i4 = 1'b1;
    din4    = v;
    @(posedge clk);
    #1;
    e.val = ref_mod(32'(v), 12);
    e.acc = cycle;
    q4.push_back(e);
    drdy_i4 = 1'b0;
  endtask

  task automatic wait_idle8();
    int n = 0;
    while (q8.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_output("timeout8", 32'(q8.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic wait_idle4();
    int n = 0;
    while (q4.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_output("timeout4", 32'(q4.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int p0;
    int n;
    logic [31:0] rv;

    // Reset state
    repeat (3) @(negedge clk);
    check_output("rst_dout", 32'(dout8), 32'h00);
    check_output("rst_drdy", 32'(drdy_o8), 32'd0);
    check_output("rst_busy", 32'(busy8), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_output("post_rst_dout", 32'(dout8), 32'h00);
    check_output("post_rst_busy", 32'(busy8), 32'd0);
    check_output("post_rst_dout4", 32'(dout4), 32'h00);

    // First strobe: busy for exactly 8 cycles, then one drdy_o
    apply_stimulus8(16'h00AB, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_output("busy_window", 32'(busy8), 32'd1);
    end
    @(negedge clk);
    check_output("busy_end", 32'(busy8), 32'd0);
    check_output("drdy_at_d", 32'(drdy_o8), 32'd1);
    wait_idle8();
    check_output("first_dout", 32'(dout8), 32'hAB);

    // Reduction vectors, each producing exactly one pulse
    for (int i = 0; i < 6; i++) begin
      p0 = pulses8;
      apply_stimulus8(vec_in[i], 1'b1);
      wait_idle8();
      check_output("vec_pulses", 32'(pulses8), 32'(p0 + 1));
      if (i < 5) check_output("vec_const", 32'(dout8), 32'(vec_exp[i]));
    end

    // Back-to-back: second strobe issued in the DONE cycle
    apply_stimulus8(16'h0100, 1'b1);
    n = 0;
    while (!drdy_o8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output("b2b_first_seen", 32'(drdy_o8), 32'd1);
    check_output("b2b_first_dout", 32'(dout8), 32'h1B);
    apply_stimulus8(16'h8000, 1'b1);
    wait_idle8();
    check_output("b2b_spacing", 32'(last_pulse8 - prev_pulse8), 32'd9);
    check_output("b2b_second_dout", 32'(dout8), 32'h2F);

    // Strobe while busy is dropped
    p0 = pulses8;
    apply_stimulus8(16'h0100, 1'b1);
    repeat (3) @(negedge clk);
    apply_stimulus8(16'hB2F4, 1'b0);
    wait_idle8();
    repeat (12) @(negedge clk);
    check_output("drop_pulses", 32'(pulses8), 32'(p0 + 1));
    check_output("drop_dout", 32'(dout8), 32'h1B);

    // rst and drdy_i together: nothing captured
    rst     = 1'b1;
    drdy_i8 = 1'b1;
    din8    = 16'h8000;
    @(posedge clk);
    #1;
    check_output("rst_wins_busy", 32'(busy8), 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    drdy_i8 = 1'b0;
    @(negedge clk);
    check_output("rst_wins_idle", 32'(busy8), 32'd0);

    // Asynchronous reset in the middle of a reduction
    apply_stimulus8(16'h8000, 1'b1);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_output("midrst_dout", 32'(dout8), 32'h00);
    check_output("midrst_busy", 32'(busy8), 32'd0);
    check_output("midrst_drdy", 32'(drdy_o8), 32'd0);
    q8.delete();
    p0 = pulses8;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check_output("midrst_no_pulse", 32'(pulses8), 32'(p0));
    apply_stimulus8(16'h0100, 1'b1);
    wait_idle8();
    check_output("midrst_recover", 32'(dout8), 32'h1B);

    // Random comparison, D=8 then D=4
    for (int i = 0; i < 1000; i++) begin
      rv = $urandom;
      apply_stimulus8(rv[15:0], 1'b1);
      wait_idle8();
    end
    p0 = pulses4;
    for (int i = 0; i < 1000; i++) begin
      rv = $urandom;
      apply_stimulus4(rv[11:0]);
      wait_idle4();
    end
    check_output("rand4_pulses", 32'(pulses4), 32'(p0 + 1000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
